houghlines_accel_hls_deadlock_report_unit: RTL
==============================================

Name: houghlines_accel_hls_deadlock_report_unit

Overview:
- Central consumer of the per-process deadlock detect units in the houghlines_accel dataflow region.
- Collects every unit's dl_detect_out and elects one origin process. Launches the token, traces it around the dependence cycle, then clears it.
- Presents one latched deadlock report (origin, cycle membership, length) over a valid/ready handshake to the debug/status path.
- One instance per dataflow region; drives the origin, dl_detect_in and token_clear inputs of all detect units.

Parameters:
- PROC_NUM, 4, number of dataflow processes (detect units); 2..32.
- TRACE_TIMEOUT, 64, max TRACE cycles before forced report; used only with the optional feature.
- PROC_ID_W, localparam, max(1, clog2(PROC_NUM)).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- dl_in_vec  in  PROC_NUM  bit p = dl_detect_out of detect unit p.
- token_visit_vec  in  PROC_NUM  bit p = OR-reduction of unit p's token_in_vec.
- origin_vec  out  PROC_NUM  one-hot origin pulse; bit p drives unit p's origin.
- dl_detect_bcast  out  1  broadcast to every unit's dl_detect_in.
- token_clear  out  1  broadcast to every unit's token_clear.
- report_valid  out  1  report available.
- report_ready  in  1  consumer accepts report.
- report_origin  out  PROC_ID_W  elected origin index.
- report_chain  out  PROC_NUM  processes visited by the token, origin included.
- report_len  out  PROC_ID_W+1  popcount(report_chain).
- report_timeout  out  1  report produced by timeout rather than closure.
- dl_flag  out  1  sticky: a deadlock was reported since reset.

Behaviour:
- Reset: every output is 0; FSM enters IDLE; origin id, chain and counters are cleared. Reset asserted mid-trace aborts immediately with no report.
- FSM states: IDLE, ORIGIN, TRACE, CLEAR, REPORT, HALT. All outputs are registered.
- IDLE: when |dl_in_vec, latch origin_id = lowest set index and go to ORIGIN. Simultaneous requests resolve to the lowest index; the others are ignored.
- ORIGIN (1 cycle):
  - origin_vec = 1<<origin_id for exactly this one cycle.
  - dl_detect_bcast rises and stays 1 through TRACE, CLEAR, REPORT and HALT.
  - chain initialises to 1<<origin_id.
  - Go to TRACE.
- TRACE:
  - Each cycle, chain |= token_visit_vec.
  - Closure: dl_in_vec[origin_id] & token_visit_vec[origin_id] -> CLEAR. Closure in the first TRACE cycle is legal (self-loop).
  - Token loss: token_visit_vec == 0 for 2 consecutive TRACE cycles -> drop dl_detect_bcast and return to IDLE, no report. A fresh election follows, earliest the next cycle.
- CLEAR (1 cycle): token_clear = 1, report fields latched; go to REPORT.
- REPORT:
  - report_valid = 1; all report_* fields stay stable until the handshake.
  - Transfer when report_valid & report_ready. dl_flag sets in the same edge; go to HALT.
  - report_ready already high on entry -> valid lasts exactly one cycle.
- HALT: terminal until reset. dl_in_vec is ignored, no new origin is issued, report_valid = 0, dl_detect_bcast held 1.
- report_len is computed combinationally from the latched chain, then registered; it equals PROC_NUM when all processes are visited.
- Latency: IDLE detect -> origin_vec pulse is 1 cycle; closure -> token_clear is 1 cycle; token_clear -> report_valid is 1 cycle.

Optional Feature:
- Macro: HOUGHLINES_ACCEL_DL_TRACE_TIMEOUT_EN.
- Defined:
  - A TRACE cycle counter starts at 0 on entering TRACE.
  - Reaching TRACE_TIMEOUT without closure or loss -> CLEAR with report_timeout = 1; chain holds whatever has been collected.
  - Token loss takes priority over timeout in the same cycle; closure takes priority over both.
- Undefined: no counter; report_timeout is tied 0; TRACE exits only by closure or loss.

Decomposition:
- Shared package houghlines_accel_hls_dl_pkg holds:
  - the FSM state encoding;
  - a PROC_ID_W width function;
  - report field widths, also used by the status-register block.
- One natural sub-module: houghlines_accel_hls_dl_prio_enc (PROC_NUM-in lowest-index one-hot/index encoder), reused for origin election.

Test Plan:
- Two-process cycle, PROC_NUM=4:
  - Stimulus: dl_in_vec=0010; then token_visit_vec 0001 -> 0010 together with dl_in_vec[1].
  - Required: origin_vec=0010 for 1 cycle, token_clear pulse, report_origin=1, chain=0011, len=2, timeout=0.
- Simultaneous requests: dl_in_vec=1010 in IDLE -> origin_id=1; unit 3 is never pulsed.
- Token loss: after ORIGIN, token_visit_vec=0 for 2 cycles -> dl_detect_bcast drops, IDLE, no report_valid; re-raising dl_in_vec=0100 elects origin 2.
- Backpressure: report_ready low 5 cycles -> report_valid and fields stable; the handshake on cycle 6 sets dl_flag, enters HALT, and later dl_in_vec=1111 produces no origin.
- Timeout with the macro defined and TRACE_TIMEOUT=8: token_visit_vec alternates 0001/0100 without closure -> report after 8 TRACE cycles, chain=0101, report_timeout=1.
- Reset asserted during TRACE: all outputs 0 asynchronously; after release, behaviour matches a fresh start.

Source files
------------

// File: rtl/houghlines_accel_hls_dl_pkg.sv
// ============================================================================
// Module   : houghlines_accel_hls_dl_pkg
// Brief    : Shared FSM encoding and report-field widths for the dataflow
//            deadlock report unit and the status-register block.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package houghlines_accel_hls_dl_pkg;

  // Report unit sequencing states
  typedef enum logic [2:0] {
    DL_IDLE   = 3'd0,
    DL_ORIGIN = 3'd1,
    DL_TRACE  = 3'd2,
    DL_CLEAR  = 3'd3,
    DL_REPORT = 3'd4,
    DL_HALT   = 3'd5
  } dl_state_e;

  // Width of a process index: max(1, clog2(proc_num))
  function automatic int dl_id_width(input int proc_num);
    int w;
    w = $clog2(proc_num);
    return (w < 1) ? 1 : w;
  endfunction

  // Width of the chain length field; holds values up to proc_num
  function automatic int dl_len_width(input int proc_num);
    return dl_id_width(proc_num) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/houghlines_accel_hls_dl_prio_enc.sv
// ============================================================================
// Module   : houghlines_accel_hls_dl_prio_enc
// Brief    : Lowest-index-wins priority encoder producing one-hot and binary
//            index of the winning request.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module houghlines_accel_hls_dl_prio_enc
  import houghlines_accel_hls_dl_pkg::*;
#(
  parameter int N = 4,
  localparam int W = dl_id_width(N)
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] onehot,
  output logic [W-1:0] index,
  output logic         any
);

  // Scan from the top down so the lowest set request is the last to win
  always_comb begin
    onehot = '0;
    index  = '0;
    any    = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        index     = W'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/houghlines_accel_hls_deadlock_report_unit.sv
// ============================================================================
// Module   : houghlines_accel_hls_deadlock_report_unit
// Brief    : Elects a deadlock origin among the dataflow detect units, traces
//            the token around the dependence cycle, clears it and presents a
//            latched report over valid/ready. Terminal after one report.
// Options  : HOUGHLINES_ACCEL_DL_TRACE_TIMEOUT_EN - bounds TRACE to
//            TRACE_TIMEOUT cycles and flags a forced report.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module houghlines_accel_hls_deadlock_report_unit
  import houghlines_accel_hls_dl_pkg::*;
#(
  parameter int PROC_NUM      = 4,
  parameter int TRACE_TIMEOUT = 64,
  localparam int PROC_ID_W    = dl_id_width(PROC_NUM)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [PROC_NUM-1:0]   dl_in_vec,
  input  logic [PROC_NUM-1:0]   token_visit_vec,
  output logic [PROC_NUM-1:0]   origin_vec,
  output logic                  dl_detect_bcast,
  output logic                  token_clear,
  output logic                  report_valid,
  input  logic                  report_ready,
  output logic [PROC_ID_W-1:0]  report_origin,
  output logic [PROC_NUM-1:0]   report_chain,
  output logic [PROC_ID_W:0]    report_len,
  output logic                  report_timeout,
  output logic                  dl_flag
);

  localparam int c_len_w = dl_len_width(PROC_NUM);

  dl_state_e             r_state, w_state_nxt;
  logic [PROC_ID_W-1:0]  r_origin_id, w_origin_id_nxt;
  logic [PROC_NUM-1:0]   r_chain, w_chain_nxt;
  logic                  r_zero_seen, w_zero_seen_nxt;
  logic [PROC_NUM-1:0]   r_origin_vec, w_origin_vec_nxt;
  logic                  r_bcast, w_bcast_nxt;
  logic                  r_token_clear, w_token_clear_nxt;
  logic                  r_valid, w_valid_nxt;
  logic [PROC_ID_W-1:0]  r_rep_origin, w_rep_origin_nxt;
  logic [PROC_NUM-1:0]   r_rep_chain, w_rep_chain_nxt;
  logic [c_len_w-1:0]    r_rep_len, w_rep_len_nxt;
  logic                  r_flag, w_flag_nxt;

  logic [PROC_NUM-1:0]   w_req_onehot;
  logic [PROC_ID_W-1:0]  w_req_index;
  logic                  w_req_any;
  logic [c_len_w-1:0]    w_chain_len;
  logic                  w_closure;
  logic                  w_no_visit;

`ifdef HOUGHLINES_ACCEL_DL_TRACE_TIMEOUT_EN
  localparam int c_cnt_w = $clog2(TRACE_TIMEOUT + 1);
  logic [c_cnt_w-1:0]    r_trace_cnt, w_trace_cnt_nxt;
  logic                  r_timeout_hit, w_timeout_hit_nxt;
  logic                  r_rep_timeout, w_rep_timeout_nxt;
`endif

  houghlines_accel_hls_dl_prio_enc #(
    .N (PROC_NUM)
  ) u_origin_elect (
    .req    (dl_in_vec),
    .onehot (w_req_onehot),
    .index  (w_req_index),
    .any    (w_req_any)
  );

  assign w_closure  = dl_in_vec[r_origin_id] & token_visit_vec[r_origin_id];
  assign w_no_visit = (token_visit_vec == '0);

  // Number of processes the token has visited so far
  always_comb begin
    w_chain_len = '0;
    for (int i = 0; i < PROC_NUM; i++) begin
      w_chain_len = w_chain_len + {{PROC_ID_W{1'b0}}, r_chain[i]};
    end
  end

  // Next-state and next-output decode; pulses default low, holds default to current
  always_comb begin
    w_state_nxt       = r_state;
    w_origin_id_nxt   = r_origin_id;
    w_chain_nxt       = r_chain;
    w_zero_seen_nxt   = r_zero_seen;
    w_origin_vec_nxt  = '0;
    w_bcast_nxt       = r_bcast;
    w_token_clear_nxt = 1'b0;
    w_valid_nxt       = r_valid;
    w_rep_origin_nxt  = r_rep_origin;
    w_rep_chain_nxt   = r_rep_chain;
    w_rep_len_nxt     = r_rep_len;
    w_flag_nxt        = r_flag;
`ifdef HOUGHLINES_ACCEL_DL_TRACE_TIMEOUT_EN
    w_trace_cnt_nxt   = r_trace_cnt;
    w_timeout_hit_nxt = r_timeout_hit;
    w_rep_timeout_nxt = r_rep_timeout;
`endif
    case (r_state)
      DL_IDLE: begin
        if (w_req_any) begin
          w_state_nxt      = DL_ORIGIN;
          w_origin_id_nxt  = w_req_index;
          w_origin_vec_nxt = w_req_onehot;
          w_chain_nxt      = w_req_onehot;
          w_bcast_nxt      = 1'b1;
        end
      end
      DL_ORIGIN: begin
        w_state_nxt     = DL_TRACE;
        w_zero_seen_nxt = 1'b0;
`ifdef HOUGHLINES_ACCEL_DL_TRACE_TIMEOUT_EN
        w_trace_cnt_nxt   = '0;
        w_timeout_hit_nxt = 1'b0;
`endif
      end
      DL_TRACE: begin
        w_chain_nxt     = r_chain | token_visit_vec;
        w_zero_seen_nxt = w_no_visit;
`ifdef HOUGHLINES_ACCEL_DL_TRACE_TIMEOUT_EN
        w_trace_cnt_nxt = r_trace_cnt + 1'b1;
`endif
        // Closure beats token loss, which beats the timeout
        if (w_closure) begin
          w_state_nxt       = DL_CLEAR;
          w_token_clear_nxt = 1'b1;
        end else if (w_no_visit && r_zero_seen) begin
          w_state_nxt = DL_IDLE;
          w_bcast_nxt = 1'b0;
        end
`ifdef HOUGHLINES_ACCEL_DL_TRACE_TIMEOUT_EN
        else if (r_trace_cnt == c_cnt_w'(TRACE_TIMEOUT - 1)) begin
          w_state_nxt       = DL_CLEAR;
          w_token_clear_nxt = 1'b1;
          w_timeout_hit_nxt = 1'b1;
        end
`endif
      end
      DL_CLEAR: begin
        w_state_nxt      = DL_REPORT;
        w_valid_nxt      = 1'b1;
        w_rep_origin_nxt = r_origin_id;
        w_rep_chain_nxt  = r_chain;
        w_rep_len_nxt    = w_chain_len;
`ifdef HOUGHLINES_ACCEL_DL_TRACE_TIMEOUT_EN
        w_rep_timeout_nxt = r_timeout_hit;
`endif
      end
      DL_REPORT: begin
        if (report_ready) begin
          w_state_nxt = DL_HALT;
          w_valid_nxt = 1'b0;
          w_flag_nxt  = 1'b1;
        end
      end
      DL_HALT: begin
        w_state_nxt = DL_HALT;
      end
      default: begin
        w_state_nxt = DL_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset aborts any trace in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= DL_IDLE;
      r_origin_id   <= '0;
      r_chain       <= '0;
      r_zero_seen   <= 1'b0;
      r_origin_vec  <= '0;
      r_bcast       <= 1'b0;
      r_token_clear <= 1'b0;
      r_valid       <= 1'b0;
      r_rep_origin  <= '0;
      r_rep_chain   <= '0;
      r_rep_len     <= '0;
      r_flag        <= 1'b0;
`ifdef HOUGHLINES_ACCEL_DL_TRACE_TIMEOUT_EN
      r_trace_cnt   <= '0;
      r_timeout_hit <= 1'b0;
      r_rep_timeout <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_origin_id   <= w_origin_id_nxt;
      r_chain       <= w_chain_nxt;
      r_zero_seen   <= w_zero_seen_nxt;
      r_origin_vec  <= w_origin_vec_nxt;
      r_bcast       <= w_bcast_nxt;
      r_token_clear <= w_token_clear_nxt;
      r_valid       <= w_valid_nxt;
      r_rep_origin  <= w_rep_origin_nxt;
      r_rep_chain   <= w_rep_chain_nxt;
      r_rep_len     <= w_rep_len_nxt;
      r_flag        <= w_flag_nxt;
`ifdef HOUGHLINES_ACCEL_DL_TRACE_TIMEOUT_EN
      r_trace_cnt   <= w_trace_cnt_nxt;
      r_timeout_hit <= w_timeout_hit_nxt;
      r_rep_timeout <= w_rep_timeout_nxt;
`endif
    end
  end

  assign origin_vec      = r_origin_vec;
  assign dl_detect_bcast = r_bcast;
  assign token_clear     = r_token_clear;
  assign report_valid    = r_valid;
  assign report_origin   = r_rep_origin;
  assign report_chain    = r_rep_chain;
  assign report_len      = r_rep_len;
  assign dl_flag         = r_flag;

`ifdef HOUGHLINES_ACCEL_DL_TRACE_TIMEOUT_EN
  assign report_timeout = r_rep_timeout;
`else
  // Without the timeout there is no forced report; the compare is always false
  assign report_timeout = (TRACE_TIMEOUT < 0);
`endif

endmodule

`default_nettype wire
